fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 151 +++++++++++++++
 tb/tb_fetch_prefetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch
// Purpose  : Instruction prefetch unit. Issues sequential fetch requests to
//            an in-order instruction cache and buffers the returned
//            instructions, tagged with their addresses, in a small FIFO.
//            A branch or flush clears the buffer and drops the responses
//            that are already in flight.
// Ports    : clk_i, rst_i (async, active-high)
//            stall_i            - downstream not accepting this cycle
//            branch_i, pc_i     - redirect fetch to pc_i
//            flush_i            - discard and replay from oldest undelivered
//            cache_ready_i      - cache accepts a request this cycle
//            addr_to_cache_o    - fetch address; req_o - request valid
//            data_cache_valid_i - in-order response valid
//            data_from_cache_i  - response instruction
//            instr_o, pc_o      - head instruction and its address + 4
//            valid_o            - head entry present
//            stall_o            - buffer empty
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  input  logic            cache_ready_i,
  output logic [XLEN-1:0] addr_to_cache_o,
  output logic            req_o,
  input  logic            data_cache_valid_i,
  input  logic [XLEN-1:0] data_from_cache_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o,
  output logic            stall_o
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_CW:0]     c_DEPTH_W = (c_CW + 1)'(DEPTH);
  localparam logic [c_PW-1:0]   c_PTR_ONE = c_PW'(1);
  localparam logic [c_CW-1:0]   c_CNT_ONE = c_CW'(1);
  localparam logic [XLEN-1:0]   c_PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [XLEN-1:0] r_addr_mem  [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop_cnt;

  logic            w_redirect;
  logic            w_empty;
  logic            w_room;
  logic            w_issue;
  logic            w_rsp;
  logic            w_keep;
  logic            w_discard;
  logic            w_pop;
  logic [XLEN-1:0] w_head_addr;
  logic [XLEN-1:0] w_restart;
  logic [c_CW-1:0] w_out_after_rsp;

  assign w_redirect  = branch_i | flush_i;
  assign w_empty     = (r_count == '0);
  assign w_head_addr = r_addr_mem[r_rd_ptr];

  // Every outstanding request owns a buffer slot, so a kept response always
  // finds room even if the consumer stalls indefinitely.
  assign w_room  = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH_W;
  assign req_o   = !rst_i && !w_redirect && w_room;
  assign w_issue = req_o && cache_ready_i;
  assign addr_to_cache_o = r_fetch_pc;

  // A response with nothing outstanding can only be a leftover from before
  // reset; it is ignored so the counters cannot underflow.
  assign w_rsp     = data_cache_valid_i && (r_outstanding != '0);
  assign w_keep    = w_rsp && (r_drop_cnt == '0);
  assign w_discard = w_rsp && (r_drop_cnt != '0);

  // Outputs are driven straight from buffer storage, so a response captured
  // on one edge is presented only after that edge.
  assign valid_o = !w_empty && !w_redirect;
  assign w_pop   = valid_o && !stall_i;
  assign instr_o = valid_o ? r_instr_mem[r_rd_ptr] : '0;
  assign pc_o    = valid_o ? (w_head_addr + c_PC_STEP) : '0;
  assign stall_o = w_empty;

  // Flush replays from the oldest instruction not yet delivered: the buffer
  // head if present, otherwise the next response address.
  assign w_restart = branch_i ? pc_i : (w_empty ? r_resp_pc : w_head_addr);

  assign w_out_after_rsp = r_outstanding - c_CW'(w_rsp);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (w_redirect) begin
      // Everything still in flight after this cycle's response belongs to
      // the old stream and is dropped on return.
      r_fetch_pc    <= w_restart;
      r_resp_pc     <= w_restart;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= w_out_after_rsp;
      r_drop_cnt    <= w_out_after_rsp;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + c_PC_STEP;
      end
      r_outstanding <= w_out_after_rsp + c_CW'(w_issue);
      if (w_discard) begin
        r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
      end
      if (w_keep) begin
        r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
        r_resp_pc <= r_resp_pc + c_PC_STEP;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count <= r_count + c_CW'(w_keep) - c_CW'(w_pop);
    end
  end

  // Storage needs no reset: the occupancy count defines what is valid.
  always_ff @(posedge clk_i) begin
    if (w_keep && !w_redirect) begin
      r_addr_mem[r_wr_ptr]  <= r_resp_pc;
      r_instr_mem[r_wr_ptr] <= data_from_cache_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_prefetch
// Purpose  : Self-checking bench for fetch_prefetch. A cache model returns
//            in-order responses with a programmable latency; a monitor keeps
//            an expected-address queue and compares every accepted output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        cache_ready_i;
  logic [31:0] addr_to_cache_o;
  logic        req_o;
  logic        data_cache_valid_i;
  logic [31:0] data_from_cache_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        stall_o;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } creq_t;

  creq_t       cq[$];
  logic [31:0] exp_q[$];
  logic [31:0] tb_fetch_pc;
  logic [31:0] mon_a;
  logic [31:0] first_addr;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_issue  = 0;
  int          issue_start;
  int          cyc = 0;
  int          lat = 1;

  fetch_prefetch #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .stall_i           (stall_i),
    .branch_i          (branch_i),
    .pc_i              (pc_i),
    .flush_i           (flush_i),
    .cache_ready_i     (cache_ready_i),
    .addr_to_cache_o   (addr_to_cache_o),
    .req_o             (req_o),
    .data_cache_valid_i(data_cache_valid_i),
    .data_from_cache_i (data_from_cache_i),
    .instr_o           (instr_o),
    .pc_o              (pc_o),
    .valid_o           (valid_o),
    .stall_o           (stall_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache model: in-order, fixed latency per request; returns every accepted
  // request, including ones the DUT is expected to drop.
  initial begin
    data_cache_valid_i = 1'b0;
    data_from_cache_i  = 32'h0;
    forever begin
      @(negedge clk);
      data_cache_valid_i = 1'b0;
      data_from_cache_i  = 32'h0;
      if (cq.size() != 0) begin
        if (cq[0].due <= cyc) begin
          data_cache_valid_i = 1'b1;
          data_from_cache_i  = mem_word(cq[0].addr);
        end
      end
      #1;
      if (rst_i) begin
        cq.delete();
      end else begin
        if (data_cache_valid_i) void'(cq.pop_front());
        if (req_o && cache_ready_i) cq.push_back('{addr_to_cache_o, cyc + lat});
      end
    end
  end

  // Scoreboard monitor: issued addresses are pushed, accepted outputs popped.
  initial begin
    tb_fetch_pc = RESET_PC;
    forever begin
      @(negedge clk);
      #1;
      if (rst_i) begin
        exp_q.delete();
        tb_fetch_pc = RESET_PC;
      end else if (branch_i || flush_i) begin
        check("redirect_valid", 32'(valid_o), 32'd0);
        check("redirect_instr", instr_o, 32'd0);
        check("redirect_req", 32'(req_o), 32'd0);
        if (branch_i) tb_fetch_pc = pc_i;
        else if (exp_q.size() != 0) tb_fetch_pc = exp_q[0];
        exp_q.delete();
      end else begin
        if (valid_o && !stall_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got pc_o 0x%08h, required no output", pc_o);
          end else begin
            mon_a = exp_q.pop_front();
            check("out_pc", pc_o, mon_a + 32'd4);
            check("out_instr", instr_o, mem_word(mon_a));
          end
        end
        if (req_o && cache_ready_i) begin
          check("issue_addr", addr_to_cache_o, tb_fetch_pc);
          exp_q.push_back(tb_fetch_pc);
          tb_fetch_pc = tb_fetch_pc + 32'd4;
          n_issue++;
        end
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    cache_ready_i = 1'b0;
    stall_i       = 1'b0;
    branch_i      = 1'b0;
    flush_i       = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_drained", 32'(exp_q.size()), 32'd0);
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_stall_o", 32'(stall_o), 32'd1);
  endtask

  task automatic wait_valid_pc(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = valid_o;
    end
    check({name, "_valid"}, 32'(valid_o), 32'd1);
    check(name, pc_o, exp_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; flush_i = 1'b0;
    pc_i = 32'h0; cache_ready_i = 1'b0; lat = 1;

    // Reset state
    @(negedge clk); #1;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_stall_o", 32'(stall_o), 32'd1);

    // Sequential streaming, latency 1
    @(negedge clk);
    rst_i = 1'b0; cache_ready_i = 1'b1;
    #1;
    check("first_req", 32'(req_o), 32'd1);
    check("first_addr", addr_to_cache_o, RESET_PC);
    @(negedge clk); #1;
    check("after_edge1_valid", 32'(valid_o), 32'd0);
    @(negedge clk); #1;
    check("after_edge2_valid", 32'(valid_o), 32'd1);
    check("after_edge2_pc", pc_o, RESET_PC + 32'd4);
    check("after_edge2_instr", instr_o, mem_word(RESET_PC));
    repeat (12) @(negedge clk);
    idle();

    // Downstream stall for 10 cycles: reservation limits to DEPTH requests
    @(negedge clk);
    lat = 1; stall_i = 1'b1; cache_ready_i = 1'b1;
    first_addr  = tb_fetch_pc;
    issue_start = n_issue;
    repeat (9) @(negedge clk);
    #1;
    check("stall_issue_count", 32'(n_issue - issue_start), 32'd4);
    check("stall_req", 32'(req_o), 32'd0);
    check("stall_pc_frozen", pc_o, first_addr + 32'd4);
    @(negedge clk);
    stall_i = 1'b0;
    repeat (8) @(negedge clk);
    idle();

    // Branch with three requests in flight, latency 3
    @(negedge clk);
    lat = 3; cache_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    branch_i = 1'b1; pc_i = 32'h100;
    @(negedge clk);
    branch_i = 1'b0;
    wait_valid_pc("branch_target_pc", 32'h104);
    repeat (8) @(negedge clk);
    idle();

    // Flush with 0x20 and 0x24 buffered
    @(negedge clk);
    lat = 1; stall_i = 1'b1; branch_i = 1'b1; pc_i = 32'h20; cache_ready_i = 1'b0;
    @(negedge clk);
    branch_i = 1'b0; cache_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cache_ready_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_buffer_full", 32'(stall_o), 32'd0);
    check("flush_instr", instr_o, 32'd0);
    @(negedge clk);
    flush_i = 1'b0; stall_i = 1'b0; cache_ready_i = 1'b1;
    wait_valid_pc("flush_refetch_pc", 32'h24);
    repeat (4) @(negedge clk);
    idle();

    // Address wrap
    @(negedge clk);
    lat = 1; branch_i = 1'b1; pc_i = 32'hFFFF_FFFC; cache_ready_i = 1'b1;
    @(negedge clk);
    branch_i = 1'b0;
    wait_valid_pc("wrap_first_pc", 32'h0);
    repeat (4) @(negedge clk);
    idle();

    // Branch and flush together during streaming (response and pop present)
    @(negedge clk);
    lat = 1; cache_ready_i = 1'b1; stall_i = 1'b0;
    repeat (5) @(negedge clk);
    branch_i = 1'b1; flush_i = 1'b1; pc_i = 32'h200;
    @(negedge clk);
    branch_i = 1'b0; flush_i = 1'b0;
    wait_valid_pc("both_branch_pc", 32'h204);
    repeat (4) @(negedge clk);
    idle();

    // Asynchronous reset mid-cycle, then restart from RESET_PC
    @(negedge clk);
    #3;
    rst_i = 1'b1;
    #1;
    check("arst_req", 32'(req_o), 32'd0);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_stall_o", 32'(stall_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0; lat = 1; cache_ready_i = 1'b1;
    wait_valid_pc("post_reset_pc", RESET_PC + 32'd4);
    repeat (6) @(negedge clk);
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
